// File: rtl/ddr_cmd_parser_pkg.sv
// Shared protocol constants for the host->board command link of the DDR game.
// Holds the frame sync byte, the command codes and the payload length each command requires.
package ddrdefs;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  localparam logic [7:0] CMD_SET_PAUSE = 8'h01;
  localparam logic [7:0] CMD_NEXT_SONG = 8'h02;
  localparam logic [7:0] CMD_SCORE_CLR = 8'h03;
  localparam logic [7:0] CMD_ARROW_WR  = 8'h04;

  localparam logic [7:0] LEN_SET_PAUSE = 8'd1;
  localparam logic [7:0] LEN_NEXT_SONG = 8'd0;
  localparam logic [7:0] LEN_SCORE_CLR = 8'd0;
  localparam logic [7:0] LEN_ARROW_WR  = 8'd4;

  localparam int DEF_ARROW_COUNT = 400;

  function automatic logic cmd_known(input logic [7:0] cmd);
    return (cmd == CMD_SET_PAUSE) || (cmd == CMD_NEXT_SONG) ||
           (cmd == CMD_SCORE_CLR) || (cmd == CMD_ARROW_WR);
  endfunction

  function automatic logic [7:0] cmd_len(input logic [7:0] cmd);
    case (cmd)
      CMD_SET_PAUSE: return LEN_SET_PAUSE;
      CMD_NEXT_SONG: return LEN_NEXT_SONG;
      CMD_SCORE_CLR: return LEN_SCORE_CLR;
      CMD_ARROW_WR:  return LEN_ARROW_WR;
      default:       return 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/ddr_cmd_parser_rx_timeout.sv
// Inter-byte watchdog: reloads on clear and flags expire once TIMEOUT_CYCLES
// consecutive non-clear cycles have elapsed. A clear in the expiry cycle suppresses it.
module rx_timeout #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // Loaded with N-1 so the N-th idle cycle after the last clear sees zero
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= LOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign expire = !clear && (cnt == '0);

endmodule

// File: rtl/ddr_cmd_parser.sv
// Host command decoder: frames UART bytes into checksummed packets and turns
// accepted packets into pause/next-song/score-clear/arrow-RAM controls.
module ddr_cmd_parser
  import ddrdefs::*;
#(
  parameter int MAX_PAYLOAD    = 4,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int ARROW_COUNT    = DEF_ARROW_COUNT,
  parameter int ARROW_ADDR_W   = 9
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic                    pause,
  output logic                    next_song,
  output logic                    score_clr,
  output logic                    arrow_we,
  output logic [ARROW_ADDR_W-1:0] arrow_addr,
  output logic [15:0]             arrow_data,
  output logic                    frame_ok,
  output logic                    frame_err,
  output logic [7:0]              err_count
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CMD     = 3'd1;
  localparam logic [2:0] S_LEN     = 3'd2;
  localparam logic [2:0] S_PAYLOAD = 3'd3;
  localparam logic [2:0] S_CHK     = 3'd4;

  localparam int IDX_W = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam logic [7:0]  MAX_LEN    = 8'(MAX_PAYLOAD);
  localparam logic [16:0] ADDR_LIMIT = 17'(ARROW_COUNT);

  logic [2:0] state;
  logic [7:0] idx_r;
  logic [7:0] cmd_r;
  logic [7:0] len_r;
  logic [7:0] sum_r;
  logic [7:0] payload [MAX_PAYLOAD];

  logic        tmo_clear;
  logic        tmo_expire;
  logic [15:0] addr_word;
  logic        addr_ok;
  logic        frame_good;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // The watchdog only runs while a frame is in progress
  assign tmo_clear = rx_valid || (state == S_IDLE);

  rx_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx_timeout (
    .clk   (clk),
    .rst   (rst),
    .clear (tmo_clear),
    .expire(tmo_expire)
  );

  assign addr_word  = {payload[0], payload[1]};
  assign addr_ok    = (cmd_r != CMD_ARROW_WR) || ({1'b0, addr_word} < ADDR_LIMIT);
  assign frame_good = (sum_r == rx_data) && cmd_known(cmd_r) &&
                      (len_r == cmd_len(cmd_r)) && addr_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      idx_r      <= '0;
      pause      <= 1'b1;
      next_song  <= 1'b0;
      score_clr  <= 1'b0;
      arrow_we   <= 1'b0;
      arrow_addr <= '0;
      arrow_data <= '0;
      frame_ok   <= 1'b0;
      frame_err  <= 1'b0;
      err_count  <= '0;
    end else begin
      next_song <= 1'b0;
      score_clr <= 1'b0;
      arrow_we  <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      if ((state != S_IDLE) && tmo_expire) begin
        state     <= S_IDLE;
        frame_err <= 1'b1;
        err_count <= sat_inc(err_count);
      end else if (rx_valid) begin
        case (state)
          S_IDLE: begin
            if (rx_data == SYNC_BYTE) state <= S_CMD;
          end
          S_CMD: state <= S_LEN;
          S_LEN: begin
            idx_r <= '0;
            if (rx_data > MAX_LEN) begin
              state     <= S_IDLE;
              frame_err <= 1'b1;
              err_count <= sat_inc(err_count);
            end else if (rx_data == 8'd0) begin
              state <= S_CHK;
            end else begin
              state <= S_PAYLOAD;
            end
          end
          S_PAYLOAD: begin
            idx_r <= idx_r + 8'd1;
            if (idx_r == len_r - 8'd1) state <= S_CHK;
          end
          S_CHK: begin
            state <= S_IDLE;
            if (frame_good) begin
              frame_ok <= 1'b1;
              case (cmd_r)
                CMD_SET_PAUSE: pause <= payload[0][0];
                CMD_NEXT_SONG: next_song <= 1'b1;
                CMD_SCORE_CLR: score_clr <= 1'b1;
                CMD_ARROW_WR: begin
                  arrow_we   <= 1'b1;
                  arrow_addr <= addr_word[ARROW_ADDR_W-1:0];
                  arrow_data <= {payload[2], payload[3]};
                end
                default: ;
              endcase
            end else begin
              frame_err <= 1'b1;
              err_count <= sat_inc(err_count);
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Frame contents carry no reset; they are always rewritten before being used
  always_ff @(posedge clk) begin
    if (rx_valid) begin
      case (state)
        S_CMD: begin
          cmd_r <= rx_data;
          sum_r <= rx_data;
        end
        S_LEN: begin
          len_r <= rx_data;
          sum_r <= sum_r + rx_data;
        end
        S_PAYLOAD: begin
          payload[idx_r[IDX_W-1:0]] <= rx_data;
          sum_r <= sum_r + rx_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_cmd_parser.sv
// Scoreboard bench for ddr_cmd_parser: each frame pushes its expected output
// snapshot and cycle; a monitor pops and compares whenever a pulse appears.
module tb_ddr_cmd_parser;

  localparam int TMO = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        pause, next_song, score_clr, arrow_we, frame_ok, frame_err;
  logic [8:0]  arrow_addr;
  logic [15:0] arrow_data;
  logic [7:0]  err_count;

  ddr_cmd_parser #(
    .MAX_PAYLOAD(4),
    .TIMEOUT_CYCLES(TMO),
    .ARROW_COUNT(400),
    .ARROW_ADDR_W(9)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .pause(pause), .next_song(next_song), .score_clr(score_clr),
    .arrow_we(arrow_we), .arrow_addr(arrow_addr), .arrow_data(arrow_data),
    .frame_ok(frame_ok), .frame_err(frame_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int edges = 0;
  always @(posedge clk) edges <= edges + 1;

  typedef struct {
    int          edge_n;
    logic        ok, err, ns, sc, we, pause;
    logic [8:0]  addr;
    logic [15:0] data;
    logic [7:0]  errc;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  logic        m_pause = 1'b1;
  logic [8:0]  m_addr = '0;
  logic [15:0] m_data = '0;
  logic [7:0]  m_errc = '0;

  task automatic push_exp(input logic ok, input logic err, input logic ns,
                          input logic sc, input logic we, input int at);
    exp_t e;
    e.edge_n = at; e.ok = ok; e.err = err; e.ns = ns; e.sc = sc; e.we = we;
    e.pause = m_pause; e.addr = m_addr; e.data = m_data; e.errc = m_errc;
    exp_q.push_back(e);
  endtask

  task automatic push_err(input int at);
    if (m_errc != 8'hFF) m_errc = m_errc + 8'd1;
    push_exp(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, at);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (frame_ok || frame_err || next_song || score_clr || arrow_we) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_event edge=%0d ok=%b err=%b ns=%b sc=%b we=%b errc=%0d required no event",
                   edges, frame_ok, frame_err, next_song, score_clr, arrow_we, err_count);
        end else begin
          e = exp_q.pop_front();
          if (edges !== e.edge_n ||
              {frame_ok, frame_err, next_song, score_clr, arrow_we, pause} !==
              {e.ok, e.err, e.ns, e.sc, e.we, e.pause} ||
              arrow_addr !== e.addr || arrow_data !== e.data || err_count !== e.errc) begin
            failures++;
            $display("FAIL event edge=%0d ok=%b err=%b ns=%b sc=%b we=%b pause=%b addr=%0d data=%h errc=%0d required edge=%0d ok=%b err=%b ns=%b sc=%b we=%b pause=%b addr=%0d data=%h errc=%0d",
                     edges, frame_ok, frame_err, next_song, score_clr, arrow_we, pause,
                     arrow_addr, arrow_data, err_count, e.edge_n, e.ok, e.err, e.ns, e.sc,
                     e.we, e.pause, e.addr, e.data, e.errc);
          end
        end
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] len,
                            input logic [31:0] pl, input logic [7:0] delta);
    logic [7:0]  sum;
    logic [7:0]  b;
    logic [15:0] aw;
    logic        accept;
    send_byte(8'hA5);
    send_byte(cmd);
    send_byte(len);
    sum = cmd + len;
    for (int i = 0; i < int'(len); i++) begin
      b = pl[31-8*i -: 8];
      send_byte(b);
      sum = sum + b;
    end
    aw = pl[31:16];
    accept = (delta == 8'd0) &&
             ((cmd == 8'h01 && len == 8'd1) || (cmd == 8'h02 && len == 8'd0) ||
              (cmd == 8'h03 && len == 8'd0) ||
              (cmd == 8'h04 && len == 8'd4 && aw < 16'd400));
    send_byte(sum + delta);
    if (accept) begin
      if (cmd == 8'h01) m_pause = pl[24];
      if (cmd == 8'h04) begin
        m_addr = aw[8:0];
        m_data = pl[15:0];
      end
      push_exp(1'b1, 1'b0, cmd == 8'h02, cmd == 8'h03, cmd == 8'h04, edges);
    end else begin
      push_err(edges);
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain pending=%0d required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_pause = 1'b1; m_addr = '0; m_data = '0; m_errc = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    apply_reset();
    @(negedge clk);
    checks++;
    if ({pause, next_song, score_clr, arrow_we, frame_ok, frame_err} !== 6'b100000) begin
      failures++;
      $display("FAIL reset_flags got=%b required 100000",
               {pause, next_song, score_clr, arrow_we, frame_ok, frame_err});
    end
    checks++;
    if (arrow_addr !== 9'd0 || arrow_data !== 16'd0 || err_count !== 8'd0) begin
      failures++;
      $display("FAIL reset_regs addr=%0d data=%h errc=%0d required 0 0 0",
               arrow_addr, arrow_data, err_count);
    end
  endtask

  task automatic test_pause();
    send_frame(8'h01, 8'd1, 32'h00000000, 8'd0);
    send_frame(8'h01, 8'd1, 32'h01000000, 8'd0);
    send_frame(8'h01, 8'd1, 32'h00000000, 8'd0);
    wait_drain("pause");
  endtask

  task automatic test_arrow();
    send_frame(8'h04, 8'd4, 32'h012CBEEF, 8'd0);
    send_frame(8'h04, 8'd4, 32'h01900000, 8'd0);
    send_frame(8'h04, 8'd4, 32'h018F1234, 8'd0);
    wait_drain("arrow");
  endtask

  task automatic test_back_to_back();
    send_frame(8'h02, 8'd0, 32'h0, 8'd1);
    send_frame(8'h02, 8'd0, 32'h0, 8'd0);
    send_frame(8'h03, 8'd0, 32'h0, 8'd0);
    wait_drain("back_to_back");
  endtask

  task automatic test_len_cmd_errors();
    send_frame(8'h07, 8'd2, 32'h55AA0000, 8'd0);
    send_frame(8'h01, 8'd0, 32'h0, 8'd0);
    send_frame(8'h02, 8'd1, 32'h33000000, 8'd0);
    send_frame(8'h03, 8'd0, 32'h0, 8'd0);
    wait_drain("len_cmd");
  endtask

  task automatic test_overflow_junk();
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'h05);
    push_err(edges);
    send_frame(8'h02, 8'd0, 32'h0, 8'd0);
    wait_drain("overflow");
  endtask

  task automatic test_timeout();
    send_byte(8'hA5);
    send_byte(8'h03);
    push_err(edges + TMO);
    repeat (TMO + 5) @(posedge clk);
    #1;
    wait_drain("timeout");
    send_byte(8'hA5);
    send_byte(8'h03);
    repeat (TMO - 1) @(posedge clk);
    #1;
    send_byte(8'h00);
    send_byte(8'h03);
    push_exp(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, edges);
    wait_drain("timeout_race");
  endtask

  task automatic test_reset_mid_frame();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h01);
    apply_reset();
    @(negedge clk);
    checks++;
    if (pause !== 1'b1 || err_count !== 8'd0 || arrow_addr !== 9'd0) begin
      failures++;
      $display("FAIL mid_frame_reset pause=%b errc=%0d addr=%0d required 1 0 0",
               pause, err_count, arrow_addr);
    end
    send_frame(8'h01, 8'd1, 32'h00000000, 8'd0);
    wait_drain("reset_mid_frame");
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 260; i++) send_frame(8'h02, 8'd0, 32'h0, 8'd7);
    wait_drain("saturation");
    checks++;
    if (err_count !== 8'd255) begin
      failures++;
      $display("FAIL saturation err_count=%0d required 255", err_count);
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_pause();
    test_arrow();
    test_back_to_back();
    test_len_cmd_errors();
    test_overflow_junk();
    test_timeout();
    test_reset_mid_frame();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
